mor1kx_branch_predictor_gshare_param: RTL
=========================================

Name: mor1kx_branch_predictor_gshare_param

Overview:
Parametrised direction predictor for l.bf/l.bnf with a table of saturating counters. The table is indexed by the branch PC, optionally XORed with a global taken/not-taken history. It generalises the fixed two-bit predictors and supports configurable table depth, counter width and history length; history length 0 gives pure bimodal mode. The prediction is issued in decode, and the table is trained when the branch resolves one stage later.

Parameters:
OPTION_OPERAND_WIDTH, 32, width of brn_pc_i.
BP_INDEX_WIDTH, 6, log2 of the number of table entries (range 1..10).
BP_COUNTER_WIDTH, 2, bits per saturating counter (range 1..4).
BP_HISTORY_WIDTH, 6, global history bits (range 0..BP_INDEX_WIDTH); 0 selects bimodal mode.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
op_bf_i  in  1  decode insn is l.bf
op_bnf_i  in  1  decode insn is l.bnf
brn_pc_i  in  OPTION_OPERAND_WIDTH  PC of the decode branch
padv_decode_i  in  1  decode stage advances
predicted_flag_o  out  1  predicted SR[F] for the decode branch
prev_op_brcond_i  in  1  decode-execute insn is a conditional branch
prev_predicted_flag_i  in  1  flag predicted for that branch
flag_i  in  1  real flag from execute-ctrl
execute_bf_i  in  1  resolving insn is l.bf
execute_bnf_i  in  1  resolving insn is l.bnf
branch_mispredict_o  out  1  resolving branch was mispredicted

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset state:
  - every counter = 2^(BP_COUNTER_WIDTH-1)-1 (weakly not-taken; 0 when width is 1);
  - history = 0;
  - pending_idx = 0, pending_valid = 0.
  - Outputs are combinational, so they reach their reset values in the same cycle: predicted_flag_o = 0 (counters read not-taken and op_bf_i=1 gives 0; op_bnf_i=1 gives 1, which is still a not-taken prediction); branch_mispredict_o follows its equation.
- Lookup index = brn_pc_i[BP_INDEX_WIDTH+1:2] XOR {zero-extend, history}. In bimodal mode there is no XOR.
- Lookup is combinational (0-cycle latency):
  - taken_pred = MSB of counter[index];
  - predicted_flag_o = op_bf_i ? taken_pred : op_bnf_i ? ~taken_pred : 0.
- Capture: on padv_decode_i & (op_bf_i | op_bnf_i), set pending_idx <= index and pending_valid <= 1.
  - On padv_decode_i with no branch op, clear pending_valid.
  - The index is frozen at prediction time, so a later history change cannot alter which entry is trained.
- Resolve/update: fires when padv_decode_i & prev_op_brcond_i & pending_valid.
  - actual_taken = execute_bf_i ? flag_i : ~flag_i (execute_bnf_i case).
  - counter[pending_idx] increments on taken, decrements otherwise, saturating at 2^BP_COUNTER_WIDTH-1 and at 0.
  - history <= {history[BP_HISTORY_WIDTH-2:0], actual_taken}.
  - History is non-speculative: it changes only on resolve.
- Stall: when padv_decode_i=0, no capture and no update occur, and all state holds.
- Simultaneous resolve and lookup in one cycle: the lookup uses the pre-update counter and pre-update history (no bypass) unless BP_BYPASS_EN is defined.
- branch_mispredict_o = prev_op_brcond_i & (flag_i != prev_predicted_flag_i). It is combinational and independent of table state.
- Reset mid-operation: a pending update is discarded and never written.
- Both op_bf_i and op_bnf_i asserted is illegal; l.bf priority applies.
- Table implementation: flops, not RAM (depth ≤ 1024 entries).

Optional Feature:
BP_BYPASS_EN
- Defined: when an update writes the same index that is being looked up in that cycle, the lookup returns the post-update counter MSB. The index is still computed from the pre-update history. This costs one comparator and a mux.
- Undefined: the lookup always sees the registered pre-update value. Predictions may differ from the bypass build only in same-index collision cycles.

Test Plan:
1. Reset state: after rst, l.bf at PC 0x100 gives predicted_flag_o=0; l.bnf at PC 0x100 gives predicted_flag_o=1.
2. Training (bimodal, BP_HISTORY_WIDTH=0): resolve l.bf at PC 0x100 with flag_i=1 once. The counter goes 1→2, and the next l.bf at 0x100 gives predicted_flag_o=1. Repeat 4×: the counter saturates at 3. Then one not-taken gives 2, and the prediction stays taken.
3. Misprediction: prev_op_brcond_i=1, prev_predicted_flag_i=0, flag_i=1 gives branch_mispredict_o=1 in the same cycle. With flag_i=0 it gives 0.
4. Gshare aliasing (default params): history 6'b000011 with PC 0x10C gives index 3^3=0. Train taken there; the same PC with history 0 (index 3) still predicts not-taken.
5. Stall: hold padv_decode_i=0 for 5 cycles with prev_op_brcond_i=1. The counter and history are unchanged. Update on the first cycle padv_decode_i=1.
6. Collision: update and lookup on index 5 in the same cycle with counter 1 → 2. Without BP_BYPASS_EN, l.bf gives predicted_flag_o=0; with it, predicted_flag_o=1.

Source files
------------

// File: rtl/mor1kx_branch_predictor_gshare_param.sv
`default_nettype none
// ============================================================================
// Module   : mor1kx_branch_predictor_gshare_param
// Brief    : gshare/bimodal l.bf/l.bnf direction predictor with a flop table
//            of saturating counters. Optional macro BP_BYPASS_EN forwards a
//            same-cycle update to a colliding lookup.
// Revision : 1.0 - initial release
// ============================================================================
module mor1kx_branch_predictor_gshare_param #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int BP_INDEX_WIDTH       = 6,
   parameter int BP_COUNTER_WIDTH     = 2,
   parameter int BP_HISTORY_WIDTH     = 6
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            op_bf_i,
   input  logic                            op_bnf_i,
   input  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i,
   input  logic                            padv_decode_i,
   output logic                            predicted_flag_o,
   input  logic                            prev_op_brcond_i,
   input  logic                            prev_predicted_flag_i,
   input  logic                            flag_i,
   input  logic                            execute_bf_i,
   input  logic                            execute_bnf_i,
   output logic                            branch_mispredict_o
);

   localparam int IW    = BP_INDEX_WIDTH;
   localparam int CW    = BP_COUNTER_WIDTH;
   localparam int DEPTH = 1 << IW;
   localparam logic [CW-1:0] CNT_INIT = CW'((1 << (CW - 1)) - 1);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic [CW-1:0] counters [DEPTH];
   logic [IW-1:0] hist_ext;
   logic [IW-1:0] lookup_idx;
   logic [IW-1:0] pending_idx;
   logic          pending_valid;
   logic          is_branch;
   logic          update;
   logic          actual_taken;
   logic [CW-1:0] cur_cnt;
   logic [CW-1:0] next_cnt;
   logic [CW-1:0] lookup_cnt;
   logic          taken_pred;

   assign is_branch    = op_bf_i | op_bnf_i;
   assign lookup_idx   = brn_pc_i[IW+1:2] ^ hist_ext;
   assign update       = padv_decode_i & prev_op_brcond_i & pending_valid;
   // Only l.bf and l.bnf can resolve here, so anything not l.bf is l.bnf.
   assign actual_taken = execute_bf_i ? flag_i : ~flag_i;
   assign cur_cnt      = counters[pending_idx];

   always_comb begin
      next_cnt = cur_cnt;
      if (actual_taken) begin
         if (cur_cnt != CNT_MAX)
            next_cnt = cur_cnt + 1'b1;
      end else if (cur_cnt != '0) begin
         next_cnt = cur_cnt - 1'b1;
      end
   end

   generate
      if (BP_HISTORY_WIDTH == 0) begin : g_bimodal
         assign hist_ext = '0;
      end else begin : g_gshare
         logic [BP_HISTORY_WIDTH-1:0] history;

         // History is non-speculative: it only moves when a branch resolves.
         always_ff @(posedge clk) begin
            if (rst)
               history <= '0;
            else if (update)
               history <= BP_HISTORY_WIDTH'({history, actual_taken});
         end

         assign hist_ext = IW'(history);
      end
   endgenerate

`ifdef BP_BYPASS_EN
   assign lookup_cnt = (update && (pending_idx == lookup_idx)) ? next_cnt
                                                               : counters[lookup_idx];
`else
   assign lookup_cnt = counters[lookup_idx];
`endif

   assign taken_pred          = lookup_cnt[CW-1];
   assign predicted_flag_o    = op_bf_i ? taken_pred : (op_bnf_i & ~taken_pred);
   assign branch_mispredict_o = prev_op_brcond_i & (flag_i ^ prev_predicted_flag_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            counters[i] <= CNT_INIT;
      end else if (update) begin
         counters[pending_idx] <= next_cnt;
      end
   end

   // The trained entry is frozen at prediction time.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_valid <= 1'b0;
         pending_idx   <= '0;
      end else if (padv_decode_i) begin
         pending_valid <= is_branch;
         if (is_branch)
            pending_idx <= lookup_idx;
      end
   end

   logic unused_inputs;
   assign unused_inputs = &{1'b0, brn_pc_i, execute_bnf_i};

endmodule
`default_nettype wire
